// File: rtl/mvm_seq_pkg.sv
// Shared types and sizing for the MVM host sequencer.
package mvm_seq_pkg;

   localparam int K       = 16;
   localparam int B       = 8;
   localparam int JOB_LEN = K * K + K;
   localparam int CNT_W   = $clog2(JOB_LEN);
   localparam int IDX_W   = $clog2(K);

   typedef logic signed [B-1:0]   elem_t;
   typedef logic signed [2*B-1:0] res_t;

   typedef enum logic [3:0] {
      S_IDLE,
      S_FILL,
      S_BURST_A,
      S_GAP_A,
      S_BURST_X,
      S_GAP_X,
      S_START,
      S_WAIT_DONE,
      S_CAPTURE,
      S_DRAIN
   } state_e;

endpackage

// File: rtl/mvm_seq_if.sv
// Host stream, result stream, status and MVM pin bundle for the sequencer.
interface mvm_seq_if import mvm_seq_pkg::*; ();

   logic  in_valid;
   logic  in_ready;
   elem_t in_data;
   logic  out_valid;
   logic  out_ready;
   res_t  out_data;
   logic  busy;
   logic  job_done;
   logic  err_timeout;
   logic  mvm_reset;
   logic  mvm_loadMatrix;
   logic  mvm_loadVector;
   logic  mvm_start;
   elem_t mvm_data_in;
   logic  mvm_done;
   res_t  mvm_data_out;

   modport master (
      input  in_valid, in_data, out_ready, mvm_done, mvm_data_out,
      output in_ready, out_valid, out_data, busy, job_done, err_timeout,
      output mvm_reset, mvm_loadMatrix, mvm_loadVector, mvm_start, mvm_data_in
   );

   modport slave (
      output in_valid, in_data, out_ready, mvm_done, mvm_data_out,
      input  in_ready, out_valid, out_data, busy, job_done, err_timeout,
      input  mvm_reset, mvm_loadMatrix, mvm_loadVector, mvm_start, mvm_data_in
   );

endinterface

// File: rtl/mvm_seq_buf.sv
// Single-port job buffer: JOB_LEN x B synchronous RAM with 1-cycle read latency.
module mvm_seq_buf
   import mvm_seq_pkg::*;
(
   input  logic             clk,
   input  logic [CNT_W-1:0] addr_i,
   input  logic             we_i,
   input  elem_t            wdata_i,
   output elem_t            rdata_o
);

   elem_t mem_q [JOB_LEN];
   elem_t rdata_q;

   always_ff @(posedge clk) begin
      if (we_i) mem_q[addr_i] <= wdata_i;
      rdata_q <= mem_q[addr_i];
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/mvm_host_sequencer.sv
// Buffers one MVM job, replays it as gapless load bursts, captures and streams y.
// Optional watchdog on WAIT_DONE enabled by defining MVM_SEQ_TIMEOUT_EN.
module mvm_host_sequencer
   import mvm_seq_pkg::*;
#(
   parameter int RESULT_LAG = 1,
   parameter int TIMEOUT    = 1024
) (
   input logic       clk,
   input logic       reset,
   mvm_seq_if.master bus
);

   localparam logic [CNT_W-1:0] LAST_ELEM = CNT_W'(JOB_LEN - 1);
   localparam logic [CNT_W-1:0] A_LEN     = CNT_W'(K * K);
   localparam logic [CNT_W-1:0] X_LEN     = CNT_W'(K);
   localparam logic [CNT_W-1:0] LAG_M1    = CNT_W'(RESULT_LAG - 1);
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(K - 1);

   if (RESULT_LAG < 1 || TIMEOUT < 1) begin : g_param_check
      $error("mvm_host_sequencer: RESULT_LAG and TIMEOUT must be >= 1");
   end

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             job_done_q, job_done_d;
   logic             mvm_reset_q;
   res_t             ybuf_q [K];

   logic             tmo;
   logic             cap_en;
   logic             buf_we;
   logic [CNT_W-1:0] buf_addr;
   elem_t            buf_rdata;
   logic             burst_dv;
   logic             load_m, load_v, start;

`ifdef MVM_SEQ_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT + 1);
   logic [WD_W-1:0] wdog_q, wdog_d;
   logic            err_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         wdog_q <= '0;
         err_q  <= 1'b0;
      end else begin
         wdog_q <= wdog_d;
         err_q  <= err_q | tmo;
      end
   end

   assign bus.err_timeout = err_q;
`else
   assign bus.err_timeout = 1'b0;
`endif

   mvm_seq_buf u_buf (
      .clk     (clk),
      .addr_i  (buf_addr),
      .we_i    (buf_we),
      .wdata_i (bus.in_data),
      .rdata_o (buf_rdata)
   );

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      idx_d      = idx_q;
      job_done_d = 1'b0;
      tmo        = 1'b0;
      cap_en     = 1'b0;
      buf_we     = 1'b0;
      buf_addr   = cnt_q;
      burst_dv   = 1'b0;
      load_m     = 1'b0;
      load_v     = 1'b0;
      start      = 1'b0;
`ifdef MVM_SEQ_TIMEOUT_EN
      wdog_d     = '0;
`endif
      unique case (state_q)
         S_IDLE: state_d = S_FILL;
         S_FILL: begin
            buf_we = bus.in_valid;
            if (bus.in_valid) begin
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == LAST_ELEM) begin
                  state_d = S_BURST_A;
                  cnt_d   = '0;
               end
            end
         end
         // Address runs one cycle ahead of mvm_data_in to hide RAM latency.
         S_BURST_A: begin
            load_m   = (cnt_q == '0);
            burst_dv = (cnt_q != '0);
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == A_LEN) begin
               state_d = S_GAP_A;
               cnt_d   = '0;
            end
         end
         S_GAP_A: state_d = S_BURST_X;
         S_BURST_X: begin
            buf_addr = (cnt_q == X_LEN) ? A_LEN : A_LEN + cnt_q;
            load_v   = (cnt_q == '0);
            burst_dv = (cnt_q != '0);
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == X_LEN) begin
               state_d = S_GAP_X;
               cnt_d   = '0;
            end
         end
         S_GAP_X: state_d = S_START;
         S_START: begin
            start   = 1'b1;
            state_d = S_WAIT_DONE;
         end
         S_WAIT_DONE: begin
            if (bus.mvm_done) begin
               state_d = S_CAPTURE;
               cnt_d   = '0;
               idx_d   = '0;
            end
`ifdef MVM_SEQ_TIMEOUT_EN
            else if (wdog_q == WD_W'(TIMEOUT - 1)) begin
               tmo     = 1'b1;
               state_d = S_FILL;
               cnt_d   = '0;
            end else begin
               wdog_d = wdog_q + 1'b1;
            end
`endif
         end
         // cnt burns off the remaining result lag before y[0] is on the bus.
         S_CAPTURE: begin
            if (cnt_q < LAG_M1) begin
               cnt_d = cnt_q + 1'b1;
            end else begin
               cap_en = 1'b1;
               idx_d  = idx_q + 1'b1;
               if (idx_q == IDX_LAST) begin
                  state_d = S_DRAIN;
                  idx_d   = '0;
                  cnt_d   = '0;
               end
            end
         end
         S_DRAIN: begin
            if (bus.out_ready) begin
               idx_d = idx_q + 1'b1;
               if (idx_q == IDX_LAST) begin
                  state_d    = S_FILL;
                  idx_d      = '0;
                  job_done_d = 1'b1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         idx_q       <= '0;
         job_done_q  <= 1'b0;
         mvm_reset_q <= 1'b1;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         idx_q       <= idx_d;
         job_done_q  <= job_done_d;
         mvm_reset_q <= tmo;
      end
   end

   always_ff @(posedge clk) begin
      if (cap_en) ybuf_q[idx_q] <= bus.mvm_data_out;
   end

   assign bus.in_ready       = (state_q == S_FILL);
   assign bus.out_valid      = (state_q == S_DRAIN);
   assign bus.out_data       = (state_q == S_DRAIN) ? ybuf_q[idx_q] : '0;
   assign bus.busy           = (state_q != S_IDLE) && (state_q != S_FILL);
   assign bus.job_done       = job_done_q;
   assign bus.mvm_reset      = mvm_reset_q;
   assign bus.mvm_loadMatrix = load_m;
   assign bus.mvm_loadVector = load_v;
   assign bus.mvm_start      = start;
   assign bus.mvm_data_in    = burst_dv ? buf_rdata : '0;

endmodule

// File: tb/tb_mvm_host_sequencer.sv
// Scoreboard bench for mvm_host_sequencer with a behavioural MVM responder.
module tb_mvm_host_sequencer;
   import mvm_seq_pkg::*;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   mvm_seq_if bus ();

   mvm_host_sequencer #(.RESULT_LAG(1), .TIMEOUT(1024)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.master)
   );

   int   checks = 0;
   int   failures = 0;
   res_t exp_q[$];
   int   job_done_cnt = 0;
   int   lm_total = 0;
   int   start_total = 0;
   elem_t a_in [K*K];
   elem_t x_in [K];

   function automatic void check(string name, longint act, longint req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endfunction

   // Monitor: pops the scoreboard on every accepted result.
   initial begin
      res_t e;
      forever begin
         @(negedge clk);
         if (!reset) begin
            if (bus.job_done) job_done_cnt++;
            if (bus.out_valid && bus.out_ready) begin
               if (exp_q.size() == 0) begin
                  check("unexpected_result", 1, 0);
               end else begin
                  e = exp_q.pop_front();
                  check("y", bus.out_data, e);
               end
               check("drain_in_ready", bus.in_ready, 0);
            end
         end
      end
   end

   // MVM responder: records bursts, checks their timing, answers with lag 1.
   initial begin
      int    cyc, ph, ai, xi, dup, s;
      int    lm_cyc, lv_cyc, done_cyc;
      elem_t a_m [K*K];
      elem_t x_m [K];
      res_t  y_m [K];
      cyc = 0; ph = 0; ai = 0; xi = 0; dup = 0;
      lm_cyc = -1000; lv_cyc = -1000; done_cyc = -1000;
      bus.mvm_done = 1'b0;
      bus.mvm_data_out = '0;
      forever begin
         @(negedge clk);
         cyc++;
         if (bus.mvm_reset) begin
            ph = 0; lm_cyc = -1000; lv_cyc = -1000;
         end else begin
            if (ph == 1) begin
               if (bus.mvm_loadMatrix) dup++;
               a_m[ai] = bus.mvm_data_in;
               ai++;
               if (ai == K*K) begin
                  ph = 0;
                  check("lm_pulses_in_burst", dup, 0);
               end
            end else if (ph == 2) begin
               x_m[xi] = bus.mvm_data_in;
               xi++;
               if (xi == K) ph = 0;
            end
            if (cyc == lm_cyc + K*K + 1) begin
               check("gap_a_data", bus.mvm_data_in, 0);
               check("gap_a_loadVector", bus.mvm_loadVector, 0);
            end
            if (cyc == lm_cyc + K*K + 2) check("loadVector_pos", bus.mvm_loadVector, 1);
            if (bus.mvm_loadMatrix && ph == 0) begin
               lm_total++; lm_cyc = cyc; ph = 1; ai = 0; dup = 0;
            end
            if (bus.mvm_loadVector) begin
               lv_cyc = cyc; ph = 2; xi = 0;
            end
            if (bus.mvm_start) begin
               start_total++;
               check("start_pos", cyc, lv_cyc + K + 2);
               for (int r = 0; r < K; r++) begin
                  s = 0;
                  for (int c = 0; c < K; c++) s += int'(a_m[r*K+c]) * int'(x_m[c]);
                  y_m[r] = res_t'(s);
               end
               done_cyc = cyc + 5;
            end
         end
         bus.mvm_done = (cyc == done_cyc) || (cyc == done_cyc + 40);
         if (cyc > done_cyc && cyc <= done_cyc + K) bus.mvm_data_out = y_m[cyc - done_cyc - 1];
         else bus.mvm_data_out = res_t'(16'h5A5A);
      end
   end

   task automatic send_elem(input elem_t d, input bit gap);
      int n;
      if (gap) begin
         @(posedge clk); #1;
         bus.in_valid = 1'b0;
      end
      @(posedge clk); #1;
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      n = 0;
      while (!bus.in_ready) begin
         n++;
         if (n > 4000) begin
            $display("FAIL in_ready_wait: got 0 after %0d cycles, expected 1", n);
            $fatal(1, "in_ready never asserted");
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic send_job(input bit gaps);
      for (int i = 0; i < K*K; i++) send_elem(a_in[i], gaps && (i > 0));
      for (int i = 0; i < K; i++) send_elem(x_in[i], gaps);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic set_identity();
      for (int r = 0; r < K; r++)
         for (int c = 0; c < K; c++) a_in[r*K+c] = (r == c) ? elem_t'(1) : elem_t'(0);
   endtask

   task automatic check_idle_outputs(string tag);
      check({tag, "_mvm_reset"}, bus.mvm_reset, 1);
      check({tag, "_in_ready"}, bus.in_ready, 0);
      check({tag, "_out_valid"}, bus.out_valid, 0);
      check({tag, "_busy"}, bus.busy, 0);
      check({tag, "_job_done"}, bus.job_done, 0);
      check({tag, "_mvm_ctl"}, {bus.mvm_loadMatrix, bus.mvm_loadVector, bus.mvm_start}, 0);
      check({tag, "_mvm_data_in"}, bus.mvm_data_in, 0);
      check({tag, "_out_data"}, bus.out_data, 0);
   endtask

   initial begin
      #400000;
      $display("FAIL global_timeout: simulation did not finish, expected completion");
      $fatal(1, "global timeout");
   end

   initial begin
      int n;
      reset = 1'b1;
      bus.in_valid = 1'b0;
      bus.in_data = '0;
      bus.out_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_idle_outputs("reset");
      check("reset_err_timeout", bus.err_timeout, 0);
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("post_reset_mvm_reset", bus.mvm_reset, 0);
      check("post_reset_in_ready", bus.in_ready, 1);

      // Identity, x = 1..16
      set_identity();
      for (int i = 0; i < K; i++) x_in[i] = elem_t'(i + 1);
      for (int i = 0; i < K; i++) exp_q.push_back(res_t'(i + 1));
      send_job(1'b0);

      // Full-scale positive: 16*127*127 wraps to -4080
      for (int i = 0; i < K*K; i++) a_in[i] = elem_t'(127);
      for (int i = 0; i < K; i++) x_in[i] = elem_t'(127);
      for (int i = 0; i < K; i++) exp_q.push_back(res_t'(-4080));
      send_job(1'b0);

      // Row r filled with r-8, x = 1..16, in_valid toggling
      for (int r = 0; r < K; r++)
         for (int c = 0; c < K; c++) a_in[r*K+c] = elem_t'(r - 8);
      for (int i = 0; i < K; i++) x_in[i] = elem_t'(i + 1);
      for (int r = 0; r < K; r++) exp_q.push_back(res_t'((r - 8) * 136));
      send_job(1'b1);

      // Identity, x = 16..1, output back-pressure
      set_identity();
      for (int i = 0; i < K; i++) x_in[i] = elem_t'(K - i);
      for (int i = 0; i < K; i++) exp_q.push_back(res_t'(K - i));
      send_job(1'b0);
      bus.out_ready = 1'b0;
      n = 0;
      @(negedge clk);
      while (!bus.out_valid && n < 2000) begin
         n++;
         @(negedge clk);
      end
      check("out_valid_seen", bus.out_valid, 1);
      for (int k = 0; k < 20; k++) begin
         check("stall_out_valid", bus.out_valid, 1);
         check("stall_out_data", bus.out_data, 16);
         check("stall_in_ready", bus.in_ready, 0);
         @(negedge clk);
      end
      @(posedge clk); #1;
      bus.out_ready = 1'b1;

      // Job aborted by reset mid-burst: no results expected
      set_identity();
      for (int i = 0; i < K; i++) x_in[i] = elem_t'(i + 1);
      send_job(1'b0);
      n = 0;
      @(negedge clk);
      while (!bus.mvm_loadMatrix && n < 2000) begin
         n++;
         @(negedge clk);
      end
      check("abort_loadMatrix_seen", bus.mvm_loadMatrix, 1);
      repeat (100) @(negedge clk);
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      check_idle_outputs("abort");
      @(negedge clk);
      check("abort_mvm_reset_pulse", bus.mvm_reset, 0);
      check("abort_in_ready", bus.in_ready, 1);

      // Fresh job after the abort
      set_identity();
      for (int i = 0; i < K; i++) x_in[i] = elem_t'(i + 1);
      for (int i = 0; i < K; i++) exp_q.push_back(res_t'(i + 1));
      send_job(1'b0);

      n = 0;
      while (exp_q.size() != 0 && n < 3000) begin
         n++;
         @(negedge clk);
      end
      repeat (5) @(negedge clk);
      check("scoreboard_empty", exp_q.size(), 0);
      check("job_done_pulses", job_done_cnt, 5);
      check("loadMatrix_total", lm_total, 6);
      check("start_total", start_total, 5);
      check("final_err_timeout", bus.err_timeout, 0);
      check("final_in_ready", bus.in_ready, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
